// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and FSM state type for the sequential multiplier
package mult_pkg;

    localparam int WIDTH  = 32;
    localparam int PROD_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_64bit.sv
// rtl/cla_64bit.sv - 64-bit carry-lookahead adder, 4-bit lookahead groups chained by group carry
module cla_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        c_in,
    output logic [63:0] sum,
    output logic        c_out
);

    logic [63:0] g;
    logic [63:0] p;
    logic [63:0] c;
    logic [15:0] gg;
    logic [15:0] gp;
    logic [15:0] gc;
    logic        cg;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar i = 0; i < 16; i++) begin : grp
        assign gg[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2]) | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                     | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
        assign gp[i] = p[4*i+3] & p[4*i+2] & p[4*i+1] & p[4*i];

        assign c[4*i]   = gc[i];
        assign c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
        assign c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & gc[i]);
        assign c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
                        | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
    end

    // group carries are resolved in a variable so the per-bit carry vector has no self-loop
    always_comb begin
        gc = '0;
        cg = c_in;
        for (int i = 0; i < 16; i++) begin
            gc[i] = cg;
            cg    = gg[i] | (gp[i] & cg);
        end
    end

    assign c_out = cg;
    assign sum   = p ^ c;

endmodule

// File: rtl/mult_seq_64.sv
// rtl/mult_seq_64.sv - shift-and-add 32x32->64 multiplier, fixed WIDTH+1 cycle latency
// Signed (mult) support is built only when MULT_SIGNED_EN is defined.
module mult_seq_64 #(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import mult_pkg::*;

    localparam int           PW   = PROD_W;
    localparam logic [5:0]   LAST = 6'(WIDTH - 1);

    state_t           state;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    sum;
    logic [PW-1:0]    step;
    logic [PW-1:0]    final_prod;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [5:0]       count;
    logic             carry_unused;

    cla_64bit u_add (
        .a     (prod),
        .b     (mcand),
        .c_in  (1'b0),
        .sum   (sum),
        .c_out (carry_unused)
    );

    assign step = mplier[0] ? sum : prod;
    assign busy = (state == BUSY);

`ifdef MULT_SIGNED_EN
    logic neg;

    assign mag_a      = (signed_op && a[WIDTH-1]) ? -a : a;
    assign mag_b      = (signed_op && b[WIDTH-1]) ? -b : b;
    assign final_prod = neg ? -step : step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg <= 1'b0;
        end else if (state == IDLE && start) begin
            neg <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
        end
    end
`else
    logic signed_unused;

    assign signed_unused = signed_op;
    assign mag_a         = a;
    assign mag_b         = b;
    assign final_prod    = step;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            count  <= '0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{(PW-WIDTH){1'b0}}, mag_a};
                        mplier <= mag_b;
                        prod   <= '0;
                        count  <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    // the last iteration folds in the sign fix so DONE sees the final value
                    prod   <= (count == LAST) ? final_prod : step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 6'd1;
                    if (count == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    hi    <= prod[PW-1:WIDTH];
                    lo    <= prod[WIDTH-1:0];
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_64.sv
// tb/tb_mult_seq_64.sv - self-checking bench: vector table, corner sequences, random vs reference product
module tb_mult_seq_64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[7];

    mult_seq_64 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic [63:0]        ux;
        logic [63:0]        uy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
`ifdef MULT_SIGNED_EN
        if (s) return 64'(sx * sy);
`else
        if (s) return ux * uy;
`endif
        return ux * uy;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, got, exp);
        end
    endtask

    // starts an op at the current negedge, returns at the negedge where done is seen
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tbv, input logic ts,
                         output logic [63:0] res, output int lat);
        logic [31:0] h0;
        logic [31:0] l0;
        logic        moved;
        h0 = hi;
        l0 = lo;
        moved = 1'b0;
        a = ta;
        b = tbv;
        signed_op = ts;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            if (hi !== h0 || lo !== l0) moved = 1'b1;
            @(negedge clk);
            lat++;
        end
        res = {hi, lo};
        check("hilo_hold_busy", {63'b0, moved}, 64'd0);
        check("done_seen", {63'b0, done}, 64'd1);
    endtask

    initial begin
        logic [63:0] res;
        logic [63:0] got;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          lat;
        int          ndone;
        int          first;

        tbl[0] = '{32'd3, 32'd5, 1'b0, 32'h0000_0000, 32'h0000_000F};
        tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[2] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h0000_0000};
        tbl[3] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF};
        tbl[4] = '{32'h8000_0000, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'h0000_0000};
`ifdef MULT_SIGNED_EN
        tbl[5] = '{32'hFFFF_FFFE, 32'd3, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001};
`else
        tbl[5] = '{32'hFFFF_FFFE, 32'd3, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA};
        tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001};
`endif

        rst_n = 1'b0;
        start = 1'b0;
        signed_op = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].s, res, lat);
            check($sformatf("vec%0d_product", i), res, {tbl[i].hi, tbl[i].lo});
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), {63'b0, done}, 64'd0);
            check($sformatf("vec%0d_idle", i), {63'b0, busy}, 64'd0);
        end

        a = 32'd7;
        b = 32'd9;
        signed_op = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        first = -1;
        got = '0;
        for (int c = 1; c <= 50; c++) begin
            if (c == 10) begin
                a = 32'd2;
                b = 32'd2;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = c;
                    got = {hi, lo};
                end
            end
        end
        check("ignore_done_count", 64'(ndone), 64'd1);
        check("ignore_latency", 64'(first), 64'd33);
        check("ignore_product", got, 64'h3F);

        a = 32'h0001_2345;
        b = 32'h0006_789A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", {63'b0, busy}, 64'd0);
        check("midreset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midreset_no_done", 64'(ndone), 64'd0);
        check("midreset_idle", {63'b0, busy}, 64'd0);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            case (i % 8)
                0: ra = 32'hFFFF_FFFF;
                1: rb = 32'h0;
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            rs = 1'($urandom_range(0, 1));
            do_op(ra, rb, rs, res, lat);
            check($sformatf("rand%0d_product", i), res, ref_prod(ra, rb, rs));
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'd33);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_seq_64.md
MULT_SEQ_64 -- requirements
Module: mult_seq_64

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width; product is 2*WIDTH (64) bits wide.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request; operands sampled on the same edge when accepted.
REQ-005 SHALL have port: signed_op  input  1  1 = signed (mult), 0 = unsigned (multu); sampled with start.
REQ-006 SHALL have port: a  input  WIDTH  multiplicand.
REQ-007 SHALL have port: b  input  WIDTH  multiplier.
REQ-008 SHALL have port: busy  output  1  high while in BUSY.
REQ-009 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port: hi  output  WIDTH  product[63:32].
REQ-011 SHALL have port: lo  output  WIDTH  product[31:0].

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL in IDLE with start=1: load 64-bit multiplicand register = magnitude of a zero-extended, multiplier register = magnitude of b, product accumulator = 0, count = 0, enter BUSY.
REQ-014 SHALL per BUSY cycle: if multiplier[0]=1, product <= product + multiplicand via the 64-bit adder (c_in=0, carry-out discarded); multiplicand <<= 1; multiplier >>= 1; count += 1.
REQ-015 SHALL leave BUSY after exactly WIDTH iterations (count = WIDTH-1 on the last) and enter DONE.
REQ-016 SHALL in DONE assert done for exactly one cycle, update hi/lo with the final product, return to IDLE.
REQ-017 SHALL give fixed latency: start accepted at edge N, done high during cycle N+WIDTH+1 (33 for WIDTH=32); no early termination.
REQ-018 SHALL hold hi/lo stable from DONE until the next DONE; hi/lo do not change during BUSY.
REQ-019 SHALL ignore start while in BUSY or DONE (no restart, no operand resample).
REQ-020 SHALL accept start in the IDLE cycle immediately after DONE (back-to-back).
REQ-021 SHALL compute unsigned product exactly for all operands, including 0 and 0xFFFFFFFF.

Reset
REQ-022 SHALL on rst_n=0, asynchronously: state=IDLE, busy=0, done=0, hi=0, lo=0, all internal registers=0.
REQ-023 SHALL on reset mid-BUSY abandon the operation; no done pulse for it after reset release.

Configuration
REQ-024 SHALL provide macro MULT_SIGNED_EN.
REQ-025 SHALL with MULT_SIGNED_EN defined and signed_op=1: operate on |a|, |b| and negate (two's complement, 64-bit) the final product when a[WIDTH-1] XOR b[WIDTH-1]; negation occurs on the BUSY->DONE transition, no extra latency.
REQ-026 SHALL without MULT_SIGNED_EN: signed_op port present but ignored, all operations unsigned; no sign/negate logic synthesised.

Structure
REQ-027 SHALL place FSM state enum (IDLE/BUSY/DONE) and constants WIDTH=32, PROD_W=64 in shared package mult_pkg.
REQ-028 SHALL instantiate existing cla_64bit as the sole adder sub-module (A=product, B=multiplicand, c_in=0); no behavioural '+' on the product path.
REQ-029 SHALL keep the iteration counter 6 bits wide.

Verification
REQ-030 SHALL cover: a=3, b=5, unsigned -> done 33 cycles after start, hi=0x00000000, lo=0x0000000F.
REQ-031 SHALL cover: a=b=0xFFFFFFFF, signed_op=0 -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 SHALL cover (MULT_SIGNED_EN): a=0xFFFFFFFE (-2), b=3, signed_op=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; a=b=0xFFFFFFFF signed -> hi=0, lo=1.
REQ-033 SHALL cover: start with a=7,b=9, then start with a=2,b=2 pulsed at cycle 10 -> ignored, single done, lo=0x3F.
REQ-034 SHALL cover: rst_n low at cycle 15 of an operation -> busy=0, hi=lo=0 immediately, no done within 40 cycles after release.
REQ-035 SHALL cover: 1000 random unsigned pairs, back-to-back starts -> {hi,lo} equals 64-bit reference product each time.
